// File: rtl/uart_sim_pkg.sv
// Shared types and constants for the simulation-side UART transmitter.
package uart_sim_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;

   // A divisor of zero would stall the prescaler; run it as the fastest rate.
   function automatic logic [15:0] eff_divisor(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/uart_sim_fifo.sv
// Synchronous FIFO with registered full/empty/level flags.
module uart_sim_fifo
   import uart_sim_pkg::*;
#(
   parameter int WIDTH = DATA_BITS,
   parameter int AW    = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_level
);

   localparam int DEPTH = 1 << AW;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             r_full;
   logic             r_empty;

   logic             w_do_push;
   logic             w_do_pop;
   logic [AW:0]      w_level_next;

   assign w_do_push = i_push && !r_full;
   assign w_do_pop  = i_pop && !r_empty;

   // Occupancy after this edge; simultaneous push and pop leave it unchanged.
   always_comb begin
      w_level_next = r_level;
      if (w_do_push && !w_do_pop) begin
         w_level_next = r_level + (AW+1)'(1);
      end else if (!w_do_push && w_do_pop) begin
         w_level_next = r_level - (AW+1)'(1);
      end
   end

   // Storage array write port.
   // NOTE: the data array is not reset; only pointers and flags define validity, and leaving it out keeps it a plain RAM.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Pointers and registered status flags.
   // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_level <= w_level_next;
         r_full  <= (w_level_next == (AW+1)'(DEPTH));
         r_empty <= (w_level_next == '0);
      end
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;
   assign o_level = r_level;

endmodule

// File: rtl/uart_sim_tx.sv
// Simulation UART transmitter: FIFO-buffered bytes serialised as 8N1/8N2
// using a 16x-oversampled bit clock derived from divisor_i.
module uart_sim_tx
   import uart_sim_pkg::*;
#(
   parameter int FIFO_AW   = 4,
   parameter int STOP_BITS = 1
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_ni,
   input  logic [7:0]         tx_data_i,
   input  logic               tx_valid_i,
   output logic               tx_ready_o,
   input  logic [15:0]        divisor_i,
   output logic               tx_o,
   output logic               busy_o,
   output logic [FIFO_AW:0]   fifo_level_o
);

   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
   localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

   tx_state_t        r_state,      w_state_next;
   logic [7:0]       r_shift,      w_shift_next;
   logic [15:0]      r_div,        w_div_next;
   logic [15:0]      r_prescale,   w_prescale_next;
   logic [3:0]       r_tick_cnt,   w_tick_cnt_next;
   logic [2:0]       r_bit_cnt,    w_bit_cnt_next;
   logic             r_stop_cnt,   w_stop_cnt_next;
   logic             r_tx,         w_tx_next;
   logic             r_busy,       w_busy_next;

   logic             w_push;
   logic             w_pop;
   logic             w_load;
   logic             w_full;
   logic             w_empty;
   logic             w_tick;
   logic             w_bit_done;
   logic [7:0]       w_fifo_dout;
   logic [FIFO_AW:0] w_level;
   logic [FIFO_AW:0] w_level_next;

   assign w_push = tx_valid_i && !w_full;
   assign w_pop  = w_load;

   uart_sim_fifo #(
      .WIDTH (DATA_BITS),
      .AW    (FIFO_AW)
   ) u_fifo (
      .i_clk   (wb_clk_i),
      .i_rst_n (wb_rst_ni),
      .i_push  (w_push),
      .i_din   (tx_data_i),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign w_tick     = (r_prescale == 16'd0);
   assign w_bit_done = w_tick && (r_tick_cnt == TICK_LAST);

   // Next-state, datapath and line value; a frame load overrides the rest.
   // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      w_state_next    = r_state;
      w_shift_next    = r_shift;
      w_div_next      = r_div;
      w_prescale_next = r_prescale;
      w_tick_cnt_next = r_tick_cnt;
      w_bit_cnt_next  = r_bit_cnt;
      w_stop_cnt_next = r_stop_cnt;
      w_tx_next       = r_tx;
      w_load          = 1'b0;

      if (r_state != IDLE) begin
         if (w_tick) begin
            w_prescale_next = r_div - 16'd1;
            w_tick_cnt_next = r_tick_cnt + 4'd1;
         end else begin
            w_prescale_next = r_prescale - 16'd1;
         end
      end

      case (r_state)
         IDLE: begin
            w_tx_next = 1'b1;
            if (!w_empty) w_load = 1'b1;
         end
         START: begin
            if (w_bit_done) begin
               w_state_next = DATA;
               w_tx_next    = r_shift[0];
            end
         end
         DATA: begin
            if (w_bit_done) begin
               w_shift_next   = {1'b0, r_shift[7:1]};
               w_bit_cnt_next = r_bit_cnt + 3'd1;
               if (r_bit_cnt == BIT_LAST) begin
                  w_state_next    = STOP;
                  w_tx_next       = 1'b1;
                  w_stop_cnt_next = 1'b0;
               end else begin
                  w_tx_next = r_shift[1];
               end
            end
         end
         STOP: begin
            if (w_bit_done) begin
               if (r_stop_cnt == STOP_LAST) begin
                  if (!w_empty) begin
                     w_load = 1'b1;
                  end else begin
                     w_state_next = IDLE;
                     w_tx_next    = 1'b1;
                  end
               end else begin
                  w_stop_cnt_next = r_stop_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
            w_tx_next    = 1'b1;
         end
      endcase

      if (w_load) begin
         w_state_next    = START;
         w_shift_next    = w_fifo_dout;
         w_div_next      = eff_divisor(divisor_i);
         w_prescale_next = eff_divisor(divisor_i) - 16'd1;
         w_tick_cnt_next = '0;
         w_bit_cnt_next  = '0;
         w_stop_cnt_next = 1'b0;
         w_tx_next       = 1'b0;
      end

      w_level_next = w_level + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
      w_busy_next  = (w_state_next != IDLE) || (w_level_next != '0);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_div      <= '0;
         r_prescale <= '0;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_shift    <= w_shift_next;
         r_div      <= w_div_next;
         r_prescale <= w_prescale_next;
         r_tick_cnt <= w_tick_cnt_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_stop_cnt <= w_stop_cnt_next;
         r_tx       <= w_tx_next;
         r_busy     <= w_busy_next;
      end
   end

   assign tx_ready_o   = !w_full;
   assign tx_o         = r_tx;
   assign busy_o       = r_busy;
   assign fifo_level_o = w_level;

endmodule

// File: tb/tb_uart_sim_tx.sv
// Self-checking bench for uart_sim_tx: waveform model, behavioural receiver,
// flow-control timing, reset abort and 8N2 framing.
module tb_uart_sim_tx;

   localparam int LOG_N = 100000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  data1, data2;
   logic        valid1, valid2;
   logic        ready1, ready2;
   logic [15:0] div1, div2;
   logic        tx1, tx2;
   logic        busy1, busy2;
   logic [4:0]  level1, level2;

   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   logic        tx_log   [0:1][0:LOG_N-1];
   logic        busy_log [0:1][0:LOG_N-1];
   logic [7:0]  tx_buf [0:31];
   logic [7:0]  rx_q [$];

   uart_sim_tx #(.FIFO_AW(4), .STOP_BITS(1)) u_dut1 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .tx_data_i(data1), .tx_valid_i(valid1),
      .tx_ready_o(ready1), .divisor_i(div1), .tx_o(tx1), .busy_o(busy1),
      .fifo_level_o(level1)
   );

   uart_sim_tx #(.FIFO_AW(4), .STOP_BITS(2)) u_dut2 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .tx_data_i(data2), .tx_valid_i(valid2),
      .tx_ready_o(ready2), .divisor_i(div2), .tx_o(tx2), .busy_o(busy2),
      .fifo_level_o(level2)
   );

   always #5 clk = ~clk;

   // Edge counter: after posedge N, cyc == N.
   always @(posedge clk) cyc <= cyc + 1;

   // Line/busy history, sampled mid-cycle; index N holds the value after edge N.
   always @(negedge clk) begin
      if (cyc < LOG_N) begin
         tx_log[0][cyc]   <= tx1;
         tx_log[1][cyc]   <= tx2;
         busy_log[0][cyc] <= busy1;
         busy_log[1][cyc] <= busy2;
      end
   end

   // Behavioural 16x receiver on instance 1: divisor taken at start-bit detect, mid-bit sampling.
   initial begin : rx_model
      int         d;
      logic [7:0] b;
      logic       prev;
      logic       ok;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n && prev && !tx1) begin
            d  = (div1 == 16'd0) ? 1 : int'(div1);
            ok = 1'b1;
            repeat (8*d) @(negedge clk);
            if (tx1 !== 1'b0) ok = 1'b0;
            for (int j = 0; j < 8; j++) begin
               repeat (16*d) @(negedge clk);
               b[j] = tx1;
            end
            repeat (16*d) @(negedge clk);
            if (tx1 !== 1'b1) ok = 1'b0;
            if (ok) rx_q.push_back(b);
         end
         prev = tx1;
      end
   end

   initial begin : watchdog
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One frame from the logged line against start/data(LSB first)/stop bits.
   task automatic check_wave(input string tag, input int sel, input int start,
                             input logic [7:0] data, input int d, input int nstop);
      int   per, idx;
      logic expb, v, uns;
      per = 16 * d;
      for (int k = 0; k < 9 + nstop; k++) begin
         if (k == 0)      expb = 1'b0;
         else if (k <= 8) expb = data[k-1];
         else             expb = 1'b1;
         idx = start + k * per;
         v   = tx_log[sel][idx];
         uns = 1'b0;
         for (int s = 0; s < per; s++) begin
            if (tx_log[sel][idx+s] !== v) uns = 1'b1;
         end
         check($sformatf("%s_bit%0d", tag, k), {30'd0, uns, v}, {31'd0, expb});
      end
   endtask

   task automatic check_rx(input string tag, input logic [7:0] exp);
      logic [7:0] got;
      got = 'x;
      if (rx_q.size() > 0) got = rx_q.pop_front();
      check(tag, {24'd0, got}, {24'd0, exp});
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_rx(input int n, input int budget);
      int b;
      b = 0;
      while (rx_q.size() < n && b < budget) begin
         @(negedge clk);
         b++;
      end
      check("rx_count", rx_q.size(), n);
   endtask

   task automatic wait_idle(input int budget);
      int b;
      b = 0;
      while (busy1 && b < budget) begin
         @(negedge clk);
         b++;
      end
      check("idle_wait", {31'd0, busy1}, 32'd0);
   endtask

   // Push tx_buf[0..n-1] into instance 1 holding valid; returns the first accept edge.
   task automatic send_stream(input int n, output int first_acc);
      int   i, budget;
      logic will;
      i = 0; budget = 0; first_acc = 0;
      @(negedge clk);
      valid1 = 1'b1;
      data1  = tx_buf[0];
      while (i < n && budget < 50000) begin
         will = ready1;
         @(negedge clk);
         budget++;
         if (will) begin
            if (i == 0) first_acc = cyc;
            i++;
            if (i < n) data1 = tx_buf[i];
            else       valid1 = 1'b0;
         end
      end
      valid1 = 1'b0;
      check("stream_accepted", i, n);
   endtask

   initial begin : main
      int         p, rel, zeros, d, i, budget;
      int         acc [0:19];
      logic [7:0] t3b [0:19];
      logic [7:0] base;
      logic       will, full_checked;

      rst_n = 1'b0; valid1 = 1'b0; data1 = '0; div1 = 16'd1;
      valid2 = 1'b0; data2 = '0; div2 = 16'd0;
      wait_cycles(3);
      check("rst_tx",    {31'd0, tx1},    32'd1);
      check("rst_ready", {31'd0, ready1}, 32'd1);
      check("rst_busy",  {31'd0, busy1},  32'd0);
      check("rst_level", {27'd0, level1}, 32'd0);
      check("rst_tx2",   {31'd0, tx2},    32'd1);
      rst_n = 1'b1;
      wait_cycles(3);

      // 0x55 at divisor 1: 160-cycle frame starting one cycle after the push edge.
      div1 = 16'd1;
      tx_buf[0] = 8'h55;
      send_stream(1, p);
      check("t1_pre_start", {31'd0, tx1}, 32'd1);
      wait_cycles(170);
      check_wave("t1", 0, p + 1, 8'h55, 1, 1);
      check("t1_idle_after", {31'd0, tx_log[0][p+161]}, 32'd1);
      check("t1_busy_last",  {31'd0, busy_log[0][p+160]}, 32'd1);
      check("t1_busy_drop",  {31'd0, busy_log[0][p+161]}, 32'd0);
      check_rx("t1_rx", 8'h55);

      // 0x00 then 0xFF at divisor 2: frames abut with no idle gap.
      div1 = 16'd2;
      tx_buf[0] = 8'h00; tx_buf[1] = 8'hFF;
      send_stream(2, p);
      wait_cycles(660);
      check_wave("t2a", 0, p + 1,       8'h00, 2, 1);
      check_wave("t2b", 0, p + 1 + 320, 8'hFF, 2, 1);
      check("t2_idle_after", {31'd0, tx_log[0][p+641]}, 32'd1);
      check_rx("t2_rx0", 8'h00);
      check_rx("t2_rx1", 8'hFF);

      // 20 distinct bytes held at divisor 26: 17 accepted to full, then one per frame.
      wait_idle(100);
      base = 8'($urandom_range(0, 255));
      for (int k = 0; k < 20; k++) t3b[k] = base + 8'(k * 37);
      div1 = 16'd26;
      i = 0; budget = 0; full_checked = 1'b0;
      @(negedge clk);
      valid1 = 1'b1;
      data1  = t3b[0];
      while (i < 20 && budget < 60000) begin
         will = ready1;
         if (!will && !full_checked) begin
            full_checked = 1'b1;
            check("t3_accepted_at_full", i, 17);
            check("t3_level_full", {27'd0, level1}, 32'd16);
         end
         @(negedge clk);
         budget++;
         if (will) begin
            acc[i] = cyc;
            i++;
            if (i < 20) data1 = t3b[i];
            else        valid1 = 1'b0;
         end
      end
      valid1 = 1'b0;
      div1   = 16'd1;   // frame 3 is in flight at 26; later frames run at 1
      check("t3_all_accepted", i, 20);
      check("t3_acc17", acc[17] - acc[0], 4162);
      check("t3_acc18", acc[18] - acc[17], 4160);
      check("t3_acc19", acc[19] - acc[18], 4160);
      wait_rx(20, 12000);
      for (int k = 0; k < 20; k++) check_rx($sformatf("t3_order%0d", k), t3b[k]);

      // "Hello\n" at divisor 26 through the receiver.
      wait_idle(200);
      div1 = 16'd26;
      tx_buf[0] = 8'h48; tx_buf[1] = 8'h65; tx_buf[2] = 8'h6C;
      tx_buf[3] = 8'h6C; tx_buf[4] = 8'h6F; tx_buf[5] = 8'h0A;
      send_stream(6, p);
      wait_rx(6, 6 * 4160 + 500);
      for (int k = 0; k < 6; k++) check_rx($sformatf("t4_rx%0d", k), tx_buf[k]);

      // Random bytes at a random small divisor, checked against the waveform model.
      wait_idle(3000);
      d = $urandom_range(1, 3);
      div1 = 16'(d);
      for (int k = 0; k < 4; k++) tx_buf[k] = 8'($urandom);
      send_stream(4, p);
      wait_cycles(4 * 160 * d + 50);
      for (int k = 0; k < 4; k++) begin
         check_wave($sformatf("t7_f%0d", k), 0, p + 1 + k * 160 * d, tx_buf[k], d, 1);
         check_rx($sformatf("t7_rx%0d", k), tx_buf[k]);
      end

      // Reset in the middle of 0xA5's data bits with three bytes queued.
      wait_idle(200);
      div1 = 16'd4;
      tx_buf[0] = 8'hA5; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
      send_stream(4, p);
      wait_cycles(1 + 64 * 4 + 20 - 3);
      check("t5_level_pre", {27'd0, level1}, 32'd3);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_async_tx",    {31'd0, tx1},    32'd1);
      check("t5_async_level", {27'd0, level1}, 32'd0);
      check("t5_async_ready", {31'd0, ready1}, 32'd1);
      check("t5_async_busy",  {31'd0, busy1},  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rel = cyc;
      wait_cycles(2000);
      zeros = 0;
      for (int k = rel; k < cyc; k++) if (tx_log[0][k] !== 1'b1) zeros++;
      check("t5_quiet_line", zeros, 0);
      check("t5_quiet_busy", {31'd0, busy1}, 32'd0);
      rx_q.delete();

      // 8N2 instance with divisor 0 (runs as 1): 176-cycle frame, 32-cycle stop.
      @(negedge clk);
      valid2 = 1'b1;
      data2  = 8'h80;
      check("t6_ready", {31'd0, ready2}, 32'd1);
      @(negedge clk);
      valid2 = 1'b0;
      p = cyc;
      wait_cycles(200);
      check_wave("t6", 1, p + 1, 8'h80, 1, 2);
      check("t6_idle_after", {31'd0, tx_log[1][p+177]}, 32'd1);
      check("t6_busy_last",  {31'd0, busy_log[1][p+176]}, 32'd1);
      check("t6_busy_drop",  {31'd0, busy_log[1][p+177]}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
